graph_sample_ctrl: RTL and testbench

- Sequences the random-walk scrolling graph by owning the 128-column sample storage, the sample-rate divider, random-step collection and the running total.
- It consumes the serial bit from the 32-bit LFSR and serves the screen-side pixel renderer through a registered read port.
- Relative to the first-cut graph logic, it adds run/pause/single-step control, saturating arithmetic and a reset-time storage clear sweep.

---
 rtl/graph_sample_ctrl.sv | 165 ++++++++++++++++
 tb/tb_graph_sample_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/graph_sample_ctrl.sv
// Random-walk graph sequencer: owns the column storage, sample-rate divider, step collection and running total.
// Latency: colData is registered, 1 cycle after colAddr; sampleStrobe is high during the commit cycle.
// Backpressure: none; run/singleStep gate sampling, and both are ignored while the reset-time clear sweep runs.
module graph_sample_ctrl #(
    parameter int SAMPLE_DIV = 900000,
    parameter int NUM_COLS   = 128,
    parameter int COL_W      = 7,
    parameter int INIT_VALUE = 127,
    parameter int STEP_BITS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             randomBit,
    input  logic             run,
    input  logic             singleStep,
    input  logic [COL_W-1:0] colAddr,
    output logic [7:0]       colData,
    output logic [COL_W-1:0] writeIndex,
    output logic [7:0]       graphValue,
    output logic             sampleStrobe,
    output logic             satHigh,
    output logic             satLow,
    output logic             busy
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BIT_W = (STEP_BITS > 1) ? $clog2(STEP_BITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(STEP_BITS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

    localparam logic [1:0] S_CLEAR   = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_COLLECT = 2'd2;
    localparam logic [1:0] S_COMMIT  = 2'd3;

    logic [1:0]           state;
    logic [COL_W-1:0]     clr_idx;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [STEP_BITS-1:0] step_buf;

    logic [7:0]           storage [NUM_COLS];

    logic signed [9:0]    delta;
    logic signed [9:0]    sum;
    logic                 clamp_hi;
    logic                 clamp_lo;
    logic [7:0]           next_value;

    logic                 mem_we;
    logic [COL_W-1:0]     mem_waddr;
    logic [7:0]           mem_wdat;
    logic [COL_W-1:0]     rd_addr;

    assign busy         = (state == S_CLEAR);
    assign sampleStrobe = (state == S_COMMIT);

    // All-ones step is treated as "no move" so the walk stays symmetric at -7..+7.
    always_comb begin
        delta = 10'sd0;
        if (step_buf != '1) begin
            delta = $signed({{(10-STEP_BITS){1'b0}}, step_buf}) - 10'sd7;
        end
        sum        = $signed({2'b00, graphValue}) + delta;
        clamp_hi   = (sum > 10'sd255);
        clamp_lo   = (sum < 10'sd0);
        next_value = sum[7:0];
        if (clamp_hi) begin
            next_value = 8'hFF;
        end else if (clamp_lo) begin
            next_value = 8'h00;
        end
    end

    // Single write port shared by the clear sweep and the commit.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = writeIndex;
        mem_wdat  = graphValue;
        if (!rst && state == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx;
            mem_wdat  = 8'h00;
        end else if (!rst && state == S_COMMIT) begin
            mem_we    = 1'b1;
        end
    end

    assign rd_addr = colAddr + writeIndex;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            storage[mem_waddr] <= mem_wdat;
        end
    end

    // Reads the pre-write contents when it collides with the commit slot.
    always_ff @(posedge clk) begin
        if (rst || state == S_CLEAR) begin
            colData <= 8'h00;
        end else begin
            colData <= storage[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_CLEAR;
            clr_idx    <= '0;
            writeIndex <= '0;
            graphValue <= 8'(INIT_VALUE);
            div_cnt    <= '0;
            bit_cnt    <= '0;
            step_buf   <= '0;
            satHigh    <= 1'b0;
            satLow     <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == COL_LAST) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (run) begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            state   <= S_COLLECT;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end else if (singleStep) begin
                        div_cnt <= '0;
                        state   <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    step_buf <= {step_buf[STEP_BITS-2:0], randomBit};
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        state   <= S_COMMIT;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_COMMIT: begin
                    writeIndex <= writeIndex + 1'b1;
                    graphValue <= next_value;
                    if (clamp_hi) begin
                        satHigh <= 1'b1;
                    end
                    if (clamp_lo) begin
                        satLow <= 1'b1;
                    end
                    state <= S_WAIT;
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_graph_sample_ctrl.sv
// Directed sequence with random bits/addresses, checked every cycle against a sample-level model of the graph.
module tb_graph_sample_ctrl;

    localparam int D = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       randomBit;
    logic       run;
    logic       singleStep;
    logic [6:0] colAddr;
    logic [7:0] colData;
    logic [6:0] writeIndex;
    logic [7:0] graphValue;
    logic       sampleStrobe;
    logic       satHigh;
    logic       satLow;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Sample-level reference: column contents, total, flags and where we are in the sample period.
    int         m_mem [128];
    int         m_wi;
    int         m_gv;
    int         m_last;
    int         m_hi;
    int         m_lo;
    bit         m_strobe;
    int         m_clear_left;
    int         m_collect_left;
    int         m_waited;
    int         m_commits;
    logic [3:0] m_step;

    bit         pat_mode;
    logic [3:0] pat;
    bit         rand_addr;
    bit         rand_ss;
    int         cyc_n;
    int         last_strobe_at;
    int         strobe_gap;

    always #5 clk = ~clk;

    graph_sample_ctrl #(
        .SAMPLE_DIV (D),
        .NUM_COLS   (128),
        .COL_W      (7),
        .INIT_VALUE (127),
        .STEP_BITS  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .randomBit    (randomBit),
        .run          (run),
        .singleStep   (singleStep),
        .colAddr      (colAddr),
        .colData      (colData),
        .writeIndex   (writeIndex),
        .graphValue   (graphValue),
        .sampleStrobe (sampleStrobe),
        .satHigh      (satHigh),
        .satLow       (satLow),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock edge: pick inputs, advance the model by the spec rules, then compare every output.
    task automatic tick();
        int exp_col;
        int delta;
        int sum;
        if (pat_mode && m_collect_left > 0) randomBit = pat[m_collect_left-1];
        else randomBit = 1'($urandom_range(0, 1));
        if (rand_addr) colAddr = 7'($urandom_range(0, 127));
        if (rand_ss) singleStep = ($urandom_range(0, 7) == 0);

        exp_col = (rst || m_clear_left > 0) ? 0 : m_mem[(int'(colAddr) + m_wi) % 128];

        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = 0;
            m_wi = 0; m_gv = 127; m_hi = 0; m_lo = 0; m_strobe = 0;
            m_clear_left = 128; m_collect_left = 0; m_waited = 0; m_step = 4'h0;
        end else if (m_clear_left > 0) begin
            m_clear_left--;
        end else if (m_strobe) begin
            delta = (m_step == 4'hF) ? 0 : int'(m_step) - 7;
            m_mem[m_wi] = m_gv;
            m_last = m_gv;
            m_wi = (m_wi + 1) % 128;
            sum = m_gv + delta;
            if (sum > 255) begin m_gv = 255; m_hi = 1; end
            else if (sum < 0) begin m_gv = 0; m_lo = 1; end
            else m_gv = sum;
            m_strobe = 0;
            m_commits++;
        end else if (m_collect_left > 0) begin
            m_step = {m_step[2:0], randomBit};
            m_collect_left--;
            if (m_collect_left == 0) m_strobe = 1;
        end else if (run) begin
            m_waited++;
            if (m_waited == D) begin m_waited = 0; m_collect_left = 4; end
        end else if (singleStep) begin
            m_waited = 0;
            m_collect_left = 4;
        end

        @(posedge clk);
        #1;
        cyc_n++;
        chk("colData", colData, exp_col);
        chk("graphValue", graphValue, m_gv);
        chk("writeIndex", writeIndex, m_wi);
        chk("sampleStrobe", sampleStrobe, m_strobe);
        chk("busy", busy, (m_clear_left > 0));
        chk("sat_flags", {satHigh, satLow}, {m_hi[0], m_lo[0]});
        if (sampleStrobe === 1'b1) begin
            strobe_gap = cyc_n - last_strobe_at;
            last_strobe_at = cyc_n;
        end
    endtask

    task automatic run_commits(input int n);
        int target;
        int guard;
        target = m_commits + n;
        guard = 0;
        while (m_commits < target && guard < 20 * n + 200) begin
            tick();
            guard++;
        end
    endtask

    task automatic wait_clear();
        while (m_clear_left > 0) tick();
    endtask

    initial begin
        int nb;
        int ns;
        int k;
        int guard;
        int exp_old;
        rst = 1'b1; run = 1'b0; singleStep = 1'b0; colAddr = 7'd0; randomBit = 1'b0;
        pat_mode = 0; pat = 4'h0; rand_addr = 0; rand_ss = 0;
        foreach (m_mem[i]) m_mem[i] = 0;
        m_wi = 0; m_gv = 127; m_last = 0; m_hi = 0; m_lo = 0; m_strobe = 0;
        m_clear_left = 0; m_collect_left = 0; m_waited = 0; m_commits = 0; m_step = 4'h0;
        cyc_n = 0; last_strobe_at = 0; strobe_gap = 0;

        tick();
        rst = 1'b0;
        wait_clear();

        // Fill storage with walk data, then reset and confirm the sweep wipes it.
        run = 1'b1; rand_addr = 1;
        run_commits(20);
        run = 1'b0; rand_addr = 0;
        rst = 1'b1;
        tick();
        chk("rst_busy", busy, 1);
        chk("rst_graphValue", graphValue, 127);
        chk("rst_writeIndex", writeIndex, 0);
        chk("rst_strobe", sampleStrobe, 0);
        chk("rst_sat", {satHigh, satLow}, 0);
        rst = 1'b0;
        nb = 1;
        guard = 0;
        do begin
            tick();
            if (busy === 1'b1) nb++;
            guard++;
        end while (busy === 1'b1 && guard < 400);
        chk("busy_len", nb, 128);
        for (int i = 0; i < 128; i++) begin
            colAddr = 7'(i);
            tick();
            chk("sweep_zero", colData, 0);
        end
        chk("clear_graphValue", graphValue, 127);

        // All-ones steps: fixed period, no movement.
        pat_mode = 1; pat = 4'hF; run = 1'b1;
        run_commits(1);
        run_commits(4);
        chk("period", strobe_gap, D + 5);
        chk("flat_graphValue", graphValue, 127);
        chk("flat_writeIndex", writeIndex, 5);

        pat = 4'hE;
        run_commits(1);
        chk("plus7_a", graphValue, 134);
        run_commits(1);
        chk("plus7_b", graphValue, 141);
        pat = 4'h0;
        run_commits(2);
        chk("minus7_back", graphValue, 127);
        run_commits(1);
        chk("minus7", graphValue, 120);
        pat = 4'hE;
        run_commits(1);

        // Saturation both ways from 127.
        run_commits(18);
        chk("sat_pre_value", graphValue, 253);
        chk("sat_pre_flag", satHigh, 0);
        run_commits(1);
        chk("sat_hi_value", graphValue, 255);
        chk("sat_hi_flag", satHigh, 1);
        run_commits(1);
        chk("sat_hi_hold", graphValue, 255);
        pat = 4'h0;
        run_commits(36);
        chk("sat_lo_pre", graphValue, 3);
        chk("sat_lo_pre_flag", satLow, 0);
        run_commits(1);
        chk("sat_lo_value", graphValue, 0);
        chk("sat_lo_flag", satLow, 1);
        chk("sat_hi_sticky", satHigh, 1);

        // Pause mid-count, then single-step.
        run = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("sat_cleared", {satHigh, satLow}, 0);
        pat_mode = 0;
        wait_clear();
        run = 1'b1;
        repeat (5) tick();
        run = 1'b0;
        ns = 0;
        repeat (1000) begin
            tick();
            if (sampleStrobe === 1'b1) ns++;
        end
        chk("pause_strobes", ns, 0);
        singleStep = 1'b1;
        tick();
        singleStep = 1'b0;
        run = 1'b1;
        k = 1;
        while (sampleStrobe !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        // Strobe cycle index counting the pulse cycle as cycle 1.
        chk("step_latency", k + 1, 6);
        run_commits(1);
        run_commits(1);
        chk("post_step_period", strobe_gap, D + 5);
        singleStep = 1'b1;
        tick();
        singleStep = 1'b0;
        run_commits(1);
        chk("ss_while_run_period", strobe_gap, D + 5);

        // Scroll wrap with random reads and stray singleStep pulses.
        run = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_clear();
        run = 1'b1; rand_addr = 1; rand_ss = 1;
        run_commits(128);
        chk("wrap_zero", writeIndex, 0);
        run_commits(2);
        chk("wrap_two", writeIndex, 2);
        rand_addr = 0; rand_ss = 0; singleStep = 1'b0;
        colAddr = 7'd127;
        exp_old = m_last;
        tick();
        chk("newest_column", colData, exp_old);
        guard = 0;
        while (!m_strobe && guard < 100) begin
            tick();
            guard++;
        end
        chk("commit_seen", sampleStrobe, 1);
        colAddr = 7'd0;
        exp_old = m_mem[m_wi];
        tick();
        chk("collision_old", colData, exp_old);

        // Reset in the middle of collection.
        guard = 0;
        while (m_collect_left != 2 && guard < 100) begin
            tick();
            guard++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midcollect_busy", busy, 1);
        chk("midcollect_strobe", sampleStrobe, 0);
        wait_clear();
        chk("midcollect_done", busy, 0);
        chk("midcollect_value", graphValue, 127);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
